// File: rtl/adc_input_capture_ctrl.sv
// -----------------------------------------------------------------------------
// adc_input_capture_ctrl
//
// Capture sequencer for the adc_input IP. A start command captures exactly
// dsize samples, either from the ADC sample interface or from an internal
// ramp (cr_test), and emits them as one AXI4-Stream packet with TLAST on the
// final beat. sr_pc flags normal packet completion and stays set until the
// next accepted start. An abort ends capture early. Any beat already in the
// output register is still delivered, and sr_pc stays low.
//
// Build option:
//   ADC_INPUT_OVF_CNT_EN - when defined, adds the ovf_cnt port and a 16-bit
//                          saturating counter of dropped ADC samples. The
//                          counter clears on each accepted start.
//
// Ports:
//   ACLK            in   clock
//   ARESETN         in   asynchronous active-low reset
//   start           in   one-cycle pulse, begins a packet (IDLE only)
//   abort           in   one-cycle pulse, terminates capture early
//   cr_test         in   ramp test-pattern select, sampled at start
//   dsize[31:0]     in   samples per packet, sampled at start (0 = ignored)
//   adc_data        in   ADC sample
//   adc_valid       in   ADC sample valid (no backpressure)
//   M_AXIS_TDATA    out  stream data
//   M_AXIS_TVALID   out  stream valid
//   M_AXIS_TLAST    out  last beat of packet
//   M_AXIS_TREADY   in   downstream ready
//   busy            out  sequencer not idle
//   sr_pc           out  packet complete (sticky)
//   ovf_cnt[15:0]   out  dropped-sample count (ADC_INPUT_OVF_CNT_EN only)
// -----------------------------------------------------------------------------
module adc_input_capture_ctrl #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              start,
  input  logic              abort,
  input  logic              cr_test,
  input  logic [31:0]       dsize,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  output logic [DATA_W-1:0] M_AXIS_TDATA,
  output logic              M_AXIS_TVALID,
  output logic              M_AXIS_TLAST,
  input  logic              M_AXIS_TREADY,
  output logic              busy,
  output logic              sr_pc
`ifdef ADC_INPUT_OVF_CNT_EN
  ,
  output logic [15:0]       ovf_cnt
`endif
);

  localparam int unsigned CNT_W = 32;
  localparam int unsigned OVF_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } state_e;

  state_e             state_q;
  state_e             state_nx;

  logic [CNT_W-1:0]   dsize_q;
  logic               test_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               abort_q;

  logic               hs_c;
  logic               room_c;
  logic               src_ok_c;
  logic [DATA_W-1:0]  src_data_c;
  logic               is_last_c;
  logic               start_ok_c;
  logic               capturing_c;
  logic               accept_c;
  logic               abort_set_c;
  logic               done_c;

  // Handshake / acceptance qualifiers
  always_comb begin
    hs_c        = M_AXIS_TVALID & M_AXIS_TREADY;
    // Output register can take a new beat if empty or emptying this cycle
    room_c      = ~M_AXIS_TVALID | M_AXIS_TREADY;
    // Ramp source is always available; ADC source only when adc_valid
    src_ok_c    = test_q | adc_valid;
    src_data_c  = test_q ? DATA_W'(cnt_q) : adc_data;
    is_last_c   = (cnt_q == (dsize_q - CNT_W'(1)));
    start_ok_c  = (state_q == IDLE) & start & ~abort & (dsize != '0);
    // An abort in this cycle already blocks acceptance
    capturing_c = (state_q == CAPTURE) & ~abort;
    accept_c    = capturing_c & src_ok_c & room_c;
  end

  // State register
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx    = state_q;
    abort_set_c = 1'b0;
    done_c      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_ok_c) begin
          state_nx = CAPTURE;
        end
      end
      CAPTURE: begin
        if (abort) begin
          // No beat left behind after this edge: straight back to idle
          if (room_c) begin
            state_nx = IDLE;
          end else begin
            state_nx    = DRAIN;
            abort_set_c = 1'b1;
          end
        end else if (accept_c && is_last_c) begin
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (hs_c) begin
          state_nx = IDLE;
          done_c   = ~abort_q & ~abort;
        end else if (abort) begin
          abort_set_c = 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Packet context, output register and status
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      dsize_q       <= '0;
      test_q        <= 1'b0;
      cnt_q         <= '0;
      abort_q       <= 1'b0;
      M_AXIS_TDATA  <= '0;
      M_AXIS_TVALID <= 1'b0;
      M_AXIS_TLAST  <= 1'b0;
      busy          <= 1'b0;
      sr_pc         <= 1'b0;
    end else begin
      busy <= (state_nx != IDLE);

      if (start_ok_c) begin
        dsize_q <= dsize;
        test_q  <= cr_test;
        cnt_q   <= '0;
        abort_q <= 1'b0;
        sr_pc   <= 1'b0;
      end

      if (accept_c) begin
        cnt_q         <= cnt_q + CNT_W'(1);
        M_AXIS_TDATA  <= src_data_c;
        M_AXIS_TVALID <= 1'b1;
        M_AXIS_TLAST  <= is_last_c;
      end else if (hs_c) begin
        M_AXIS_TVALID <= 1'b0;
        M_AXIS_TLAST  <= 1'b0;
      end

      if (abort_set_c) begin
        abort_q <= 1'b1;
      end

      if (done_c) begin
        sr_pc <= 1'b1;
      end
    end
  end

`ifdef ADC_INPUT_OVF_CNT_EN
  logic drop_c;

  // ADC sample offered while capturing but the output register is full
  always_comb begin
    drop_c = capturing_c & ~test_q & adc_valid & ~room_c;
  end

  // Saturating drop counter
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ovf_cnt <= '0;
    end else if (start_ok_c) begin
      ovf_cnt <= '0;
    end else if (drop_c && (ovf_cnt != '1)) begin
      ovf_cnt <= ovf_cnt + OVF_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_adc_input_capture_ctrl.sv
// -----------------------------------------------------------------------------
// tb_adc_input_capture_ctrl
//
// Self-checking bench for adc_input_capture_ctrl. A behavioural model tracks
// which offered samples become beats and what the stream should carry. Each
// scenario task compares the captured stream and status against that model
// or against fixed expected values. Inputs are driven and outputs observed
// on the falling edge.
// -----------------------------------------------------------------------------
module tb_adc_input_capture_ctrl;

  localparam int unsigned DATA_W = 16;
  localparam int          TMO    = 2000;

  localparam int RM_ALWAYS = 0;
  localparam int RM_TOGGLE = 1;
  localparam int RM_WINDOW = 2;
  localparam int RM_RAND   = 3;
  localparam int VM_CONT   = 0;
  localparam int VM_RAND   = 1;

  logic              ACLK;
  logic              ARESETN;
  logic              start;
  logic              abort;
  logic              cr_test;
  logic [31:0]       dsize;
  logic [DATA_W-1:0] adc_data;
  logic              adc_valid;
  logic [DATA_W-1:0] M_AXIS_TDATA;
  logic              M_AXIS_TVALID;
  logic              M_AXIS_TLAST;
  logic              M_AXIS_TREADY;
  logic              busy;
  logic              sr_pc;
`ifdef ADC_INPUT_OVF_CNT_EN
  logic [15:0]       ovf_cnt;
`endif

  adc_input_capture_ctrl #(.DATA_W(DATA_W)) dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .start         (start),
    .abort         (abort),
    .cr_test       (cr_test),
    .dsize         (dsize),
    .adc_data      (adc_data),
    .adc_valid     (adc_valid),
    .M_AXIS_TDATA  (M_AXIS_TDATA),
    .M_AXIS_TVALID (M_AXIS_TVALID),
    .M_AXIS_TLAST  (M_AXIS_TLAST),
    .M_AXIS_TREADY (M_AXIS_TREADY),
    .busy          (busy),
    .sr_pc         (sr_pc)
`ifdef ADC_INPUT_OVF_CNT_EN
    ,
    .ovf_cnt       (ovf_cnt)
`endif
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int n_checks = 0;
  int n_pass   = 0;

  // Results of the last run_packet call
  logic [DATA_W-1:0] got_d[$];
  bit                got_l[$];
  logic [DATA_W-1:0] exp_d[$];
  bit                exp_l[$];
  int                exp_drops;
  int                tv_err;
  int                busy_err;
  int                hold_err;
  int                sr_err;
  bit                timeout;
  bit                aborted;

  task automatic idle_inputs();
    start         = 1'b0;
    abort         = 1'b0;
    cr_test       = 1'b0;
    dsize         = 32'd0;
    adc_data      = '0;
    adc_valid     = 1'b0;
    M_AXIS_TREADY = 1'b0;
  endtask

  // Starts one packet and runs it to completion while the model predicts the
  // stream. Returns at the falling edge after the final handshake.
  task automatic run_packet(input bit test, input int unsigned ds, input int rmode,
                            input int lo, input int hi, input int vmode,
                            input int abort_cyc, input int xstart_cyc,
                            input logic [DATA_W-1:0] base);
    int unsigned taken;
    bit          active;
    bit          pend;
    bit          rdy;
    bit          av;
    bit          ab;
    bit          acc;
    bit          prev_stall;
    bit          done;
    logic [DATA_W-1:0] prev_d;
    bit                prev_l;
    logic [DATA_W-1:0] samp;
    got_d.delete(); got_l.delete(); exp_d.delete(); exp_l.delete();
    exp_drops = 0; tv_err = 0; busy_err = 0; hold_err = 0; sr_err = 0;
    timeout = 1'b0; aborted = 1'b0;
    taken = 0; active = 1'b1; pend = 1'b0; prev_stall = 1'b0; done = 1'b0;
    prev_d = '0; prev_l = 1'b0; samp = base;

    @(negedge ACLK);
    start = 1'b1; dsize = ds; cr_test = test; adc_valid = 1'b0; abort = 1'b0;
    M_AXIS_TREADY = 1'b0;

    for (int cyc = 0; cyc < TMO; cyc++) begin
      @(negedge ACLK);
      case (rmode)
        RM_ALWAYS: rdy = 1'b1;
        RM_TOGGLE: rdy = (cyc % 2 == 0);
        RM_WINDOW: rdy = !(cyc >= lo && cyc < hi);
        default:   rdy = ($urandom_range(0, 3) != 0);
      endcase
      av = (vmode == VM_CONT) ? 1'b1 : 1'(($urandom_range(0, 1)));
      ab = (cyc == abort_cyc);
      M_AXIS_TREADY = rdy;
      adc_valid     = av;
      adc_data      = samp;
      abort         = ab;
      start         = (cyc == xstart_cyc);
      dsize         = (cyc == xstart_cyc) ? 32'd3 : $urandom;
      cr_test       = ~test;

      // Observe the DUT going into this edge
      if (M_AXIS_TVALID !== pend) tv_err++;
      if (busy !== 1'b1) busy_err++;
      if (sr_pc !== 1'b0) sr_err++;
      if (prev_stall && (M_AXIS_TVALID !== 1'b1 || M_AXIS_TDATA !== prev_d ||
                         M_AXIS_TLAST !== prev_l)) hold_err++;
      if (M_AXIS_TVALID === 1'b1 && rdy) begin
        got_d.push_back(M_AXIS_TDATA);
        got_l.push_back(M_AXIS_TLAST);
      end
      prev_stall = (M_AXIS_TVALID === 1'b1) && !rdy;
      prev_d     = M_AXIS_TDATA;
      prev_l     = M_AXIS_TLAST;

      // Model: a beat enters the output slot if a sample exists and the slot
      // is free or being emptied by this cycle's handshake
      acc = 1'b0;
      if (active && !ab) begin
        if ((test || av) && (!pend || rdy)) begin
          exp_d.push_back(test ? DATA_W'(taken) : samp);
          exp_l.push_back(taken == ds - 1);
          taken++;
          acc = 1'b1;
          if (taken == ds) active = 1'b0;
        end else if (!test && av) begin
          exp_drops++;
        end
      end
      if (ab) begin
        active  = 1'b0;
        aborted = 1'b1;
      end
      if (acc) pend = 1'b1;
      else if (pend && rdy) pend = 1'b0;
      if (av) samp++;
      if (!active && !pend) begin
        done = 1'b1;
        break;
      end
    end
    timeout = !done;
    @(negedge ACLK);
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    ARESETN = 1'b1;
    #3 ARESETN = 1'b0;
    #2;
    n_checks++; if (M_AXIS_TVALID !== 1'b0) $display("FAIL rst_tvalid got %b exp 0", M_AXIS_TVALID); else n_pass++;
    n_checks++; if (M_AXIS_TLAST !== 1'b0) $display("FAIL rst_tlast got %b exp 0", M_AXIS_TLAST); else n_pass++;
    n_checks++; if (M_AXIS_TDATA !== '0) $display("FAIL rst_tdata got %h exp 0", M_AXIS_TDATA); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy); else n_pass++;
    n_checks++; if (sr_pc !== 1'b0) $display("FAIL rst_sr_pc got %b exp 0", sr_pc); else n_pass++;
`ifdef ADC_INPUT_OVF_CNT_EN
    n_checks++; if (ovf_cnt !== 16'd0) $display("FAIL rst_ovf got %0d exp 0", ovf_cnt); else n_pass++;
`endif
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_idle_busy got %b exp 0", busy); else n_pass++;
  endtask

  task automatic test_adc_basic();
    run_packet(1'b0, 4, RM_ALWAYS, 0, 0, VM_CONT, -1, -1, 16'h0010);
    n_checks++; if (timeout) $display("FAIL basic_timeout got 1 exp 0"); else n_pass++;
    n_checks++; if (got_d.size() != 4) $display("FAIL basic_count got %0d exp 4", got_d.size()); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (got_d[i] !== 16'(16'h0010 + i) || got_l[i] !== (i == 3))
        $display("FAIL basic_beat%0d got %h/%b exp %h/%b", i, got_d[i], got_l[i], 16'(16'h0010 + i), (i == 3));
      else n_pass++;
    end
    n_checks++; if (tv_err != 0 || busy_err != 0 || sr_err != 0) $display("FAIL basic_timing got tv=%0d busy=%0d sr=%0d exp 0", tv_err, busy_err, sr_err); else n_pass++;
    n_checks++; if (sr_pc !== 1'b1) $display("FAIL basic_sr_pc got %b exp 1", sr_pc); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL basic_busy_end got %b exp 0", busy); else n_pass++;
  endtask

  task automatic test_test_mode();
    run_packet(1'b1, 5, RM_TOGGLE, 0, 0, VM_RAND, -1, -1, 16'h7000);
    n_checks++; if (timeout) $display("FAIL ramp_timeout got 1 exp 0"); else n_pass++;
    n_checks++; if (got_d.size() != 5) $display("FAIL ramp_count got %0d exp 5", got_d.size()); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (got_d[i] !== 16'(i) || got_l[i] !== (i == 4))
        $display("FAIL ramp_beat%0d got %h/%b exp %h/%b", i, got_d[i], got_l[i], 16'(i), (i == 4));
      else n_pass++;
    end
    n_checks++; if (tv_err != 0 || hold_err != 0) $display("FAIL ramp_flow got tv=%0d hold=%0d exp 0", tv_err, hold_err); else n_pass++;
    n_checks++; if (sr_pc !== 1'b1) $display("FAIL ramp_sr_pc got %b exp 1", sr_pc); else n_pass++;
`ifdef ADC_INPUT_OVF_CNT_EN
    n_checks++; if (ovf_cnt !== 16'd0) $display("FAIL ramp_ovf got %0d exp 0", ovf_cnt); else n_pass++;
`endif
  endtask

  task automatic test_stall_drops();
    logic [DATA_W-1:0] want[8];
    want = '{16'h40, 16'h41, 16'h42, 16'h46, 16'h47, 16'h48, 16'h49, 16'h4A};
    run_packet(1'b0, 8, RM_WINDOW, 3, 6, VM_CONT, -1, -1, 16'h0040);
    n_checks++; if (timeout) $display("FAIL stall_timeout got 1 exp 0"); else n_pass++;
    n_checks++; if (got_d.size() != 8) $display("FAIL stall_count got %0d exp 8", got_d.size()); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (got_d[i] !== want[i] || got_l[i] !== (i == 7))
        $display("FAIL stall_beat%0d got %h/%b exp %h/%b", i, got_d[i], got_l[i], want[i], (i == 7));
      else n_pass++;
    end
    n_checks++; if (hold_err != 0) $display("FAIL stall_hold got %0d exp 0", hold_err); else n_pass++;
    n_checks++; if (sr_pc !== 1'b1) $display("FAIL stall_sr_pc got %b exp 1", sr_pc); else n_pass++;
`ifdef ADC_INPUT_OVF_CNT_EN
    n_checks++; if (ovf_cnt !== 16'd3) $display("FAIL stall_ovf got %0d exp 3", ovf_cnt); else n_pass++;
`endif
  endtask

  task automatic test_ignored_start();
    @(negedge ACLK);
    start = 1'b1; dsize = 32'd0;
    @(negedge ACLK);
    idle_inputs();
    n_checks++; if (busy !== 1'b0) $display("FAIL zero_busy got %b exp 0", busy); else n_pass++;
    n_checks++; if (sr_pc !== 1'b1) $display("FAIL zero_sr_pc got %b exp 1", sr_pc); else n_pass++;
    start = 1'b1; abort = 1'b1; dsize = 32'd5;
    @(negedge ACLK);
    idle_inputs();
    n_checks++; if (busy !== 1'b0 || sr_pc !== 1'b1) $display("FAIL start_abort got busy=%b sr=%b exp 0/1", busy, sr_pc); else n_pass++;
    run_packet(1'b0, 6, RM_ALWAYS, 0, 0, VM_CONT, -1, 2, 16'h0080);
    n_checks++; if (timeout) $display("FAIL busy_start_timeout got 1 exp 0"); else n_pass++;
    n_checks++; if (got_d.size() != 6) $display("FAIL busy_start_count got %0d exp 6", got_d.size()); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (got_d[i] !== 16'(16'h0080 + i) || got_l[i] !== (i == 5))
        $display("FAIL busy_start_beat%0d got %h/%b exp %h/%b", i, got_d[i], got_l[i], 16'(16'h0080 + i), (i == 5));
      else n_pass++;
    end
    n_checks++; if (sr_pc !== 1'b1 || busy !== 1'b0) $display("FAIL busy_start_end got sr=%b busy=%b exp 1/0", sr_pc, busy); else n_pass++;
  endtask

  task automatic test_abort();
    run_packet(1'b0, 10, RM_WINDOW, 2, 5, VM_CONT, 2, -1, 16'h0020);
    n_checks++; if (timeout) $display("FAIL abort_timeout got 1 exp 0"); else n_pass++;
    n_checks++; if (got_d.size() != 2) $display("FAIL abort_count got %0d exp 2", got_d.size()); else n_pass++;
    n_checks++; if (got_d[0] !== 16'h0020 || got_d[1] !== 16'h0021) $display("FAIL abort_data got %h,%h exp 0020,0021", got_d[0], got_d[1]); else n_pass++;
    n_checks++; if (got_l[0] !== 1'b0 || got_l[1] !== 1'b0) $display("FAIL abort_tlast got %b,%b exp 0,0", got_l[0], got_l[1]); else n_pass++;
    n_checks++; if (hold_err != 0 || tv_err != 0) $display("FAIL abort_hold got hold=%0d tv=%0d exp 0", hold_err, tv_err); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy got %b exp 0", busy); else n_pass++;
    n_checks++; if (sr_pc !== 1'b0) $display("FAIL abort_sr_pc got %b exp 0", sr_pc); else n_pass++;
  endtask

  task automatic test_reset_mid();
    @(negedge ACLK);
    start = 1'b1; dsize = 32'd6; cr_test = 1'b0;
    @(negedge ACLK);
    start = 1'b0; adc_valid = 1'b1; adc_data = 16'h1234; M_AXIS_TREADY = 1'b0;
    repeat (3) @(negedge ACLK);
    n_checks++; if (M_AXIS_TVALID !== 1'b1 || busy !== 1'b1) $display("FAIL midrst_pre got tv=%b busy=%b exp 1/1", M_AXIS_TVALID, busy); else n_pass++;
    @(posedge ACLK);
    #2 ARESETN = 1'b0;
    #1;
    n_checks++; if (M_AXIS_TVALID !== 1'b0 || busy !== 1'b0) $display("FAIL midrst_async got tv=%b busy=%b exp 0/0", M_AXIS_TVALID, busy); else n_pass++;
    n_checks++; if (M_AXIS_TDATA !== '0 || M_AXIS_TLAST !== 1'b0 || sr_pc !== 1'b0) $display("FAIL midrst_outs got d=%h l=%b sr=%b exp 0/0/0", M_AXIS_TDATA, M_AXIS_TLAST, sr_pc); else n_pass++;
    @(negedge ACLK);
    idle_inputs();
    ARESETN = 1'b1;
    run_packet(1'b0, 3, RM_ALWAYS, 0, 0, VM_CONT, -1, -1, 16'h00A0);
    n_checks++; if (timeout || got_d.size() != 3) $display("FAIL midrst_count got %0d exp 3", got_d.size()); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (got_d[i] !== 16'(16'h00A0 + i) || got_l[i] !== (i == 2))
        $display("FAIL midrst_beat%0d got %h/%b exp %h/%b", i, got_d[i], got_l[i], 16'(16'h00A0 + i), (i == 2));
      else n_pass++;
    end
    n_checks++; if (sr_pc !== 1'b1) $display("FAIL midrst_sr_pc got %b exp 1", sr_pc); else n_pass++;
  endtask

  task automatic test_dsize1();
    run_packet(1'b0, 1, RM_ALWAYS, 0, 0, VM_CONT, -1, -1, 16'h0055);
    n_checks++; if (timeout || got_d.size() != 1) $display("FAIL ds1_count got %0d exp 1", got_d.size()); else n_pass++;
    n_checks++; if (got_d[0] !== 16'h0055 || got_l[0] !== 1'b1) $display("FAIL ds1_beat got %h/%b exp 0055/1", got_d[0], got_l[0]); else n_pass++;
    n_checks++; if (sr_pc !== 1'b1 || busy !== 1'b0) $display("FAIL ds1_end got sr=%b busy=%b exp 1/0", sr_pc, busy); else n_pass++;
  endtask

  task automatic test_back_to_back();
    for (int p = 0; p < 8; p++) begin
      bit          t;
      int unsigned ds;
      int          ab;
      int          bad;
      t  = 1'($urandom_range(0, 1));
      ds = $urandom_range(1, 16);
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, ds)) : -1;
      run_packet(t, ds, RM_RAND, 0, 0, VM_RAND, ab, -1, 16'($urandom));
      n_checks++; if (timeout) $display("FAIL rand%0d_timeout got 1 exp 0", p); else n_pass++;
      n_checks++; if (got_d.size() != exp_d.size()) $display("FAIL rand%0d_count got %0d exp %0d", p, got_d.size(), exp_d.size()); else n_pass++;
      if (!aborted) begin
        n_checks++; if (got_d.size() != ds) $display("FAIL rand%0d_len got %0d exp %0d", p, got_d.size(), ds); else n_pass++;
      end
      bad = 0;
      for (int i = 0; i < exp_d.size(); i++)
        if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) bad++;
      n_checks++; if (bad != 0) $display("FAIL rand%0d_beats got %0d wrong beats exp 0", p, bad); else n_pass++;
      n_checks++; if (tv_err != 0 || hold_err != 0 || busy_err != 0 || sr_err != 0)
        $display("FAIL rand%0d_flow got tv=%0d hold=%0d busy=%0d sr=%0d exp 0", p, tv_err, hold_err, busy_err, sr_err); else n_pass++;
      n_checks++; if (sr_pc !== !aborted || busy !== 1'b0) $display("FAIL rand%0d_end got sr=%b busy=%b exp %b/0", p, sr_pc, busy, !aborted); else n_pass++;
`ifdef ADC_INPUT_OVF_CNT_EN
      n_checks++; if (ovf_cnt !== 16'(exp_drops)) $display("FAIL rand%0d_ovf got %0d exp %0d", p, ovf_cnt, exp_drops); else n_pass++;
`endif
    end
  endtask

  initial begin
    test_reset();
    test_adc_basic();
    test_test_mode();
    test_stall_drops();
    test_ignored_start();
    test_abort();
    test_reset_mid();
    test_dsize1();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got no finish exp finish before 2000000");
    $fatal(1);
  end

endmodule
